// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-port operation codes and
// the address-width helper used by the top level.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_ROL  = 3'd7
  } op_t;

  localparam int OP_W = 3;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational result/carry generator for one write-port operation applied
// to the current contents r of the target register.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] r,
  input  logic [BITS-1:0] D,
  input  op_t             op,
  output logic [BITS-1:0] result,
  output logic            carry
);

  // Operation decode; carry is the bit that falls out of the operation.
  always_comb begin
    result = r;
    carry  = 1'b0;
    case (op)
      OP_HOLD: begin
        result = r;
        carry  = 1'b0;
      end
      OP_LOAD: result = D;
      OP_CLR:  result = '0;
      OP_INC:  {carry, result} = {1'b0, r} + {{BITS{1'b0}}, 1'b1};
      OP_DEC: begin
        result = r - {{(BITS-1){1'b0}}, 1'b1};
        carry  = (r == '0);
      end
      OP_SHL: begin
        result = {r[BITS-2:0], 1'b0};
        carry  = r[BITS-1];
      end
      OP_SHR: begin
        result = {1'b0, r[BITS-1:1]};
        carry  = r[0];
      end
      OP_ROL: begin
        result = {r[BITS-2:0], r[BITS-1]};
        carry  = r[BITS-1];
      end
      default: begin
        result = r;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// NREGS x BITS register bank with one operate/write port, two combinational
// read ports and registered carry/zero flags of the last executed operation.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int BITS  = 8,
  parameter  int NREGS = 4,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] D,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [BITS-1:0] qa,
  output logic [BITS-1:0] qb,
  output logic            carry,
  output logic            zero
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [BITS-1:0] regs_r [NREGS];
  logic [BITS-1:0] cur_s;
  logic [BITS-1:0] result_s;
  logic            alu_carry_s;
  logic            waddr_ok_s;
  logic            write_s;
  logic            carry_r;
  logic            zero_r;
  op_t             op_s;

  assign op_s       = op_t'(op);
  assign waddr_ok_s = ({1'b0, waddr} < NREGS_W);
  assign write_s    = en && (op_s != OP_HOLD) && waddr_ok_s;
  assign cur_s      = waddr_ok_s ? regs_r[waddr] : '0;

  reg_bank_alu #(.BITS(BITS)) u_alu (
    .r      (cur_s),
    .D      (D),
    .op     (op_s),
    .result (result_s),
    .carry  (alu_carry_s)
  );

  // Register storage; only the addressed register is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (write_s && (waddr == AW'(i))) regs_r[i] <= result_s;
      end
    end
  end

  // Status flags follow the last executed write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (write_s) begin
      carry_r <= alu_carry_s;
      zero_r  <= (result_s == '0);
    end
  end

  // Out-of-range read addresses return zero rather than an undefined entry.
  assign qa    = ({1'b0, raddr_a} < NREGS_W) ? regs_r[raddr_a] : '0;
  assign qb    = ({1'b0, raddr_b} < NREGS_W) ? regs_r[raddr_b] : '0;
  assign carry = carry_r;
  assign zero  = zero_r;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: arithmetic reference model checked every cycle,
// plus literal expectations for the reset, wrap, borrow, shift and bypass cases.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [1:0] waddr;
  logic [7:0] D;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [7:0] qa;
  logic [7:0] qb;
  logic       carry;
  logic       zero;

  logic       en3;
  logic [2:0] op3;
  logic [1:0] waddr3;
  logic [7:0] d3;
  logic [1:0] ra3;
  logic [1:0] rb3;
  logic [7:0] qa3;
  logic [7:0] qb3;
  logic       c3;
  logic       z3;

  int vectors;
  int miscompares;

  reg_bank #(.BITS(8), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .waddr(waddr), .D(D),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .qa(qa), .qb(qb),
    .carry(carry), .zero(zero)
  );

  reg_bank #(.BITS(8), .NREGS(3)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .op(op3), .waddr(waddr3), .D(d3),
    .raddr_a(ra3), .raddr_b(rb3), .qa(qa3), .qb(qb3),
    .carry(c3), .zero(z3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {carry, result} using plain integer arithmetic.
  function automatic logic [8:0] model_op(input int o, input int r, input int d);
    int res;
    int c;
    res = r;
    c   = 0;
    case (o)
      1: res = d;
      2: res = 0;
      3: begin c = (r == 255) ? 1 : 0; res = (r + 1) % 256; end
      4: begin c = (r == 0) ? 1 : 0;   res = (r + 255) % 256; end
      5: begin c = r / 128; res = (r * 2) % 256; end
      6: begin c = r % 2;   res = r / 2; end
      7: begin c = r / 128; res = (r * 2) % 256 + r / 128; end
      default: begin c = 0; res = r; end
    endcase
    return {c[0], res[7:0]};
  endfunction

  logic [7:0] m [4];
  logic       mc;
  logic       mz;
  logic [8:0] mnext;

  assign mnext = model_op(int'(op), int'(m[waddr]), int'(D));

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m[i] <= 8'h00;
      mc <= 1'b0;
      mz <= 1'b0;
    end else if (en && (op != 3'd0)) begin
      m[waddr] <= mnext[7:0];
      mc       <= mnext[8];
      mz       <= (mnext[7:0] == 8'h00);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("model_qa", 32'(qa), 32'(m[raddr_a]));
    chk("model_qb", 32'(qb), 32'(m[raddr_b]));
    chk("model_carry", 32'(carry), 32'(mc));
    chk("model_zero", 32'(zero), 32'(mz));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d);
    en = 1'b1; op = o; waddr = a; D = d;
    step();
    en = 1'b0; op = OP_HOLD;
  endtask

  task automatic do_op3(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d);
    en3 = 1'b1; op3 = o; waddr3 = a; d3 = d;
    step();
    en3 = 1'b0; op3 = OP_HOLD;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; en = 1'b0; op = OP_HOLD; waddr = 2'd0; D = 8'h00;
    raddr_a = 2'd0; raddr_b = 2'd0;
    en3 = 1'b0; op3 = OP_HOLD; waddr3 = 2'd0; d3 = 8'h00; ra3 = 2'd0; rb3 = 2'd0;
    #1 reset = 1'b0;
    step(); step();
    chk("rst_qa", 32'(qa), 32'h00);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    reset = 1'b1;

    // First op right after release, then async reset mid-cycle
    raddr_a = 2'd1;
    do_op(OP_LOAD, 2'd1, 8'h55);
    chk("first_op", 32'(qa), 32'h55);
    do_op(OP_CLR, 2'd0, 8'h00);
    chk("clr_zero", 32'(zero), 32'h1);
    #1;
    reset = 1'b0; en = 1'b1; op = OP_LOAD; waddr = 2'd3; D = 8'h99;
    #1;
    chk("async_rst_qa", 32'(qa), 32'h00);
    chk("async_rst_zero", 32'(zero), 32'h0);
    chk("async_rst_carry", 32'(carry), 32'h0);
    step();
    raddr_b = 2'd3;
    #1;
    chk("rst_wins", 32'(qb), 32'h00);
    reset = 1'b1; en = 1'b0; op = OP_HOLD;

    // Load / read, disabled write
    do_op(OP_LOAD, 2'd2, 8'h28);
    do_op(OP_LOAD, 2'd3, 8'h38);
    raddr_a = 2'd2; raddr_b = 2'd3;
    #1;
    chk("load_qa", 32'(qa), 32'h28);
    chk("load_qb", 32'(qb), 32'h38);
    en = 1'b0; op = OP_LOAD; waddr = 2'd2; D = 8'hFF;
    step();
    op = OP_HOLD;
    chk("en0_qa", 32'(qa), 32'h28);
    chk("en0_zero", 32'(zero), 32'h0);

    // Increment wrap (D set to ones to show it is ignored)
    raddr_a = 2'd0;
    do_op(OP_LOAD, 2'd0, 8'hFF);
    do_op(OP_INC, 2'd0, 8'hFF);
    chk("inc_wrap_q", 32'(qa), 32'h00);
    chk("inc_wrap_c", 32'(carry), 32'h1);
    chk("inc_wrap_z", 32'(zero), 32'h1);
    do_op(OP_HOLD, 2'd0, 8'h12);
    chk("hold_c", 32'(carry), 32'h1);
    chk("hold_z", 32'(zero), 32'h1);
    do_op(OP_INC, 2'd0, 8'h00);
    chk("inc_q", 32'(qa), 32'h01);
    chk("inc_c", 32'(carry), 32'h0);
    chk("inc_z", 32'(zero), 32'h0);

    // Decrement borrow
    raddr_a = 2'd1;
    do_op(OP_CLR, 2'd1, 8'h00);
    do_op(OP_DEC, 2'd1, 8'h00);
    chk("dec_q", 32'(qa), 32'hFF);
    chk("dec_c", 32'(carry), 32'h1);
    chk("dec_z", 32'(zero), 32'h0);

    // Shifts and rotate
    raddr_a = 2'd2;
    do_op(OP_LOAD, 2'd2, 8'h81);
    do_op(OP_SHL, 2'd2, 8'h00);
    chk("shl_q", 32'(qa), 32'h02);
    chk("shl_c", 32'(carry), 32'h1);
    do_op(OP_SHR, 2'd2, 8'h00);
    chk("shr1_q", 32'(qa), 32'h01);
    chk("shr1_c", 32'(carry), 32'h0);
    do_op(OP_SHR, 2'd2, 8'h00);
    chk("shr2_q", 32'(qa), 32'h00);
    chk("shr2_c", 32'(carry), 32'h1);
    chk("shr2_z", 32'(zero), 32'h1);
    do_op(OP_LOAD, 2'd2, 8'h81);
    do_op(OP_ROL, 2'd2, 8'h00);
    chk("rol_q", 32'(qa), 32'h03);
    chk("rol_c", 32'(carry), 32'h1);
    chk("rol_z", 32'(zero), 32'h0);

    // Read during write: old value before the edge, new after
    raddr_a = 2'd0; raddr_b = 2'd0;
    en = 1'b1; op = OP_LOAD; waddr = 2'd0; D = 8'h7E;
    #1;
    chk("rdw_old", 32'(qa), 32'h01);
    step();
    en = 1'b0; op = OP_HOLD;
    chk("rdw_new", 32'(qa), 32'h7E);
    chk("same_addr", 32'(qb), 32'h7E);

    // Three-register instance: address 3 is out of range
    do_op3(OP_LOAD, 2'd2, 8'hAA);
    do_op3(OP_CLR, 2'd0, 8'h00);
    do_op3(OP_LOAD, 2'd3, 8'hFF);
    do_op3(OP_DEC, 2'd3, 8'h00);
    ra3 = 2'd3; rb3 = 2'd2;
    #1;
    chk("n3_oob_z", 32'(z3), 32'h1);
    chk("n3_oob_c", 32'(c3), 32'h0);
    chk("n3_oob_read", 32'(qa3), 32'h00);
    chk("n3_r2", 32'(qb3), 32'hAA);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
